// File: rtl/aemb_pkg.sv
// Shared AEMB2 definitions: divider state encoding, iteration count and
// the operand magnitude helper used at issue time.
package aemb_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

  // Two's-complement magnitude; raw value when the operation is unsigned.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/aemb_idiv_step.sv
// One restoring shift-subtract iteration: {R,Q} <<= 1, then subtract the
// divisor from R and set Q[0] when R is large enough.
module aemb_idiv_step
  import aemb_pkg::*;
(
  input  logic [64:0] i_rq,
  input  logic [31:0] i_dvs,
  output logic [64:0] o_rq
);

  logic [32:0] w_rsh;
  logic [31:0] w_qsh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic        w_unused;

  // R stays below the divisor between steps, so R[32] is always shifted out as 0.
  assign w_unused = i_rq[64];

  always_comb begin
    w_rsh  = i_rq[63:31];
    w_qsh  = {i_rq[30:0], 1'b0};
    w_diff = w_rsh - {1'b0, i_dvs};
    w_ge   = (w_rsh >= {1'b0, i_dvs});
    o_rq   = {w_rsh, w_qsh};
    if (w_ge) begin
      o_rq = {w_diff, w_qsh[31:1], 1'b1};
    end
  end

endmodule

// File: rtl/aemb_idiv.sv
// Iterative 32-bit idiv/idivu for the AEMB2 execute stage: one quotient bit
// per enabled clock, reported to the pipeline through busy/done.
module aemb_idiv
  import aemb_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dena,
  input  logic        x_start,
  input  logic [31:0] x_opa,
  input  logic [31:0] x_opb,
  input  logic        x_uns,
  output logic [31:0] m_div,
  output logic        m_dz,
  output logic        m_busy,
  output logic        m_done
);

  generate
    if (DIV != 0) begin : g_div

      div_state_t           r_state;
      div_state_t           w_nxt;
      logic [DIV_CNT_W-1:0] r_cnt;
      logic [32:0]          r_rem;
      logic [31:0]          r_quo;
      logic [31:0]          r_dvs;
      logic                 r_sgn;
      logic [31:0]          r_div;
      logic                 r_dz;
      logic [64:0]          w_step;
      logic                 w_zero;
      logic                 w_last;

      assign w_zero = (x_opa == '0);
      assign w_last = (r_cnt == DIV_CNT_W'(DIV_ITER - 1));

      aemb_idiv_step u_step (
        .i_rq  ({r_rem, r_quo}),
        .i_dvs (r_dvs),
        .o_rq  (w_step)
      );

      always_ff @(posedge gclk) begin
        if (grst) begin
          r_state <= DIV_IDLE;
        end else if (dena) begin
          r_state <= w_nxt;
        end
      end

      always_comb begin
        w_nxt = r_state;
        case (r_state)
          DIV_IDLE: if (x_start) w_nxt = w_zero ? DIV_DONE : DIV_CALC;
          DIV_CALC: if (w_last) w_nxt = DIV_FIX;
          DIV_FIX:  w_nxt = DIV_DONE;
          DIV_DONE: w_nxt = DIV_IDLE;
          default:  w_nxt = DIV_IDLE;
        endcase
      end

      always_ff @(posedge gclk) begin
        if (grst) begin
          r_cnt <= '0;
          r_rem <= '0;
          r_quo <= '0;
          r_dvs <= '0;
          r_sgn <= 1'b0;
          r_div <= '0;
          r_dz  <= 1'b0;
        end else if (dena) begin
          case (r_state)
            DIV_IDLE: begin
              if (x_start) begin
                if (w_zero) begin
                  r_div <= '0;
                  r_dz  <= 1'b1;
                end else begin
                  r_dvs <= div_mag(x_opa, ~x_uns);
                  r_quo <= div_mag(x_opb, ~x_uns);
                  r_rem <= '0;
                  r_sgn <= ~x_uns & (x_opa[31] ^ x_opb[31]);
                  r_cnt <= '0;
                  r_dz  <= 1'b0;
                end
              end
            end
            DIV_CALC: begin
              {r_rem, r_quo} <= w_step;
              r_cnt          <= r_cnt + 1'b1;
            end
            DIV_FIX: begin
              r_div <= r_sgn ? (~r_quo + 32'd1) : r_quo;
            end
            default: ;
          endcase
        end
      end

      assign m_div  = r_div;
      assign m_dz   = r_dz;
      assign m_busy = (r_state == DIV_CALC) || (r_state == DIV_FIX);
      // Gated so a stalled DONE still yields exactly one enabled-cycle pulse.
      assign m_done = (r_state == DIV_DONE) && dena;

    end else begin : g_nodiv

      logic r_pend;

      always_ff @(posedge gclk) begin
        if (grst) begin
          r_pend <= 1'b0;
        end else if (dena) begin
          r_pend <= x_start;
        end
      end

      assign m_div  = '0;
      assign m_dz   = 1'b0;
      assign m_busy = 1'b0;
      assign m_done = r_pend && dena;

    end
  endgenerate

endmodule

// File: tb/tb_aemb_idiv.sv
// Scoreboard bench for aemb_idiv: expected results queued at issue, popped on m_done.
module tb_aemb_idiv;

  logic        gclk = 1'b0;
  logic        grst;
  logic        dena;
  logic        x_start;
  logic [31:0] x_opa;
  logic [31:0] x_opb;
  logic        x_uns;
  logic [31:0] m_div;
  logic        m_dz;
  logic        m_busy;
  logic        m_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 gclk = ~gclk;

  aemb_idiv #(.DIV(1)) dut (
    .gclk    (gclk),
    .grst    (grst),
    .dena    (dena),
    .x_start (x_start),
    .x_opa   (x_opa),
    .x_opb   (x_opb),
    .x_uns   (x_uns),
    .m_div   (m_div),
    .m_dz    (m_dz),
    .m_busy  (m_busy),
    .m_done  (m_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns);
    longint sa, sb_, q;
    if (uns) return b / a;
    sa = $signed(a);
    sb_ = $signed(b);
    q = sb_ / sa;
    return q[31:0];
  endfunction

  // Issue one operation and follow it to m_done; stall_at/inject_at of 0 disable those.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        input logic [31:0] eq, input logic edz, input int elat,
                        input int stall_at, input int inject_at);
    exp_t e;
    bit   seen;
    seen    = 0;
    x_opa   = a;
    x_opb   = b;
    x_uns   = uns;
    x_start = 1'b1;
    sb.push_back('{eq, edz, elat});
    tick;
    x_start = 1'b0;
    x_opa   = $urandom;
    x_opb   = $urandom;
    x_uns   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 120 && !seen; k++) begin
      check("busy", {31'd0, m_busy}, (k < elat) ? 32'd1 : 32'd0);
      if (m_done) begin
        seen = 1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", m_div, e.q);
          check("dz", {31'd0, m_dz}, {31'd0, e.dz});
          check("latency", k, e.lat);
        end
      end else begin
        if (k == stall_at) dena = 1'b0;
        if (k == stall_at + 5) dena = 1'b1;
        if (k == inject_at) begin
          x_start = 1'b1;
          x_opa   = 32'd3;
          x_opb   = 32'd1000;
          x_uns   = 1'b1;
        end
        if (k == inject_at + 1) x_start = 1'b0;
        tick;
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
    dena    = 1'b1;
    x_start = 1'b0;
    tick;
    check("done_pulse", {31'd0, m_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        ru;

    grst    = 1'b1;
    dena    = 1'b1;
    x_start = 1'b0;
    x_opa   = '0;
    x_opb   = '0;
    x_uns   = 1'b0;
    repeat (3) tick;
    check("rst_div", m_div, 32'd0);
    check("rst_dz", {31'd0, m_dz}, 32'd0);
    check("rst_busy", {31'd0, m_busy}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    grst = 1'b0;
    tick;

    run_op(32'd7, 32'd100, 1'b1, 32'h0000000E, 1'b0, 34, 0, 0);
    run_op(32'd7, 32'hFFFFFF9C, 1'b0, 32'hFFFFFFF2, 1'b0, 34, 0, 0);
    run_op(32'd1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 34, 0, 0);
    run_op(32'd1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 34, 0, 0);
    run_op(32'd0, 32'h00001234, 1'b0, 32'h00000000, 1'b1, 1, 0, 0);
    run_op(32'd3, 32'd10, 1'b0, 32'd3, 1'b0, 34, 0, 0);
    run_op(32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 34, 0, 0);
    run_op(32'd7, 32'd100, 1'b1, 32'd14, 1'b0, 39, 10, 0);
    run_op(32'd7, 32'd100, 1'b1, 32'd14, 1'b0, 34, 0, 5);

    // Leave a nonzero quotient behind, then abandon an operation with reset.
    x_opa   = 32'd7;
    x_opb   = 32'd100;
    x_uns   = 1'b1;
    x_start = 1'b1;
    tick;
    x_start = 1'b0;
    repeat (14) tick;
    check("midop_busy", {31'd0, m_busy}, 32'd1);
    grst = 1'b1;
    tick;
    grst = 1'b0;
    check("rst_mid_busy", {31'd0, m_busy}, 32'd0);
    check("rst_mid_div", m_div, 32'd0);
    check("rst_mid_dz", {31'd0, m_dz}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      check("rst_no_done", {31'd0, m_done}, 32'd0);
      tick;
    end
    run_op(32'd5, 32'd1000, 1'b1, 32'd200, 1'b0, 34, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if (ra == 32'd0) ra = 32'd1;
      rb = $urandom;
      ru = 1'($urandom_range(0, 1));
      run_op(ra, rb, ru, model(ra, rb, ru), 1'b0, 34, 0, 0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
